// File: rtl/sar_seq_pkg.sv
// rtl/sar_seq_pkg.sv - shared state encoding and counter sizing for the SAR scan sequencer
package sar_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_START,
        ST_WAIT_EOC,
        ST_STORE,
        ST_DONE
    } seq_state_e;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_result_bank.sv
// rtl/sar_result_bank.sv - per-channel result registers with valid bits
// Ports: clk/rst (sync, active-high); write port we/wr_ch/wr_data/wr_set
// (wr_set=1 stores data and sets valid, wr_set=0 only clears valid);
// combinational read port rd_ch -> rd_data/rd_valid.
module sar_result_bank #(
    parameter int Width = 6,
    parameter int NumCh = 4,
    parameter int ChW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ChW-1:0]   wr_ch,
    input  logic [Width-1:0] wr_data,
    input  logic             wr_set,
    input  logic [ChW-1:0]   rd_ch,
    output logic [Width-1:0] rd_data,
    output logic             rd_valid
);

    logic [Width-1:0] data_q [NumCh];
    logic [NumCh-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumCh; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_ch] <= wr_set;
            // A failed conversion keeps the previous result, only validity drops.
            if (wr_set) begin
                data_q[wr_ch] <= wr_data;
            end
        end
    end

    assign rd_data  = data_q[rd_ch];
    assign rd_valid = valid_q[rd_ch];

endmodule

// File: rtl/sar_scan_sequencer.sv
// rtl/sar_scan_sequencer.sv - multi-channel scan controller driving the SAR conversion FSM
// Ports: clk_i/rst_i (sync, active-high); scan_i/cont_i/ch_en_i scan control;
// sar_start_o/sar_eoc_i/sar_result_i converter handshake; ch_sel_o mux select;
// busy_o/scan_done_o/timeout_o status; rd_ch_i -> rd_data_o/rd_valid_o readout.
module sar_scan_sequencer
    import sar_seq_pkg::*;
#(
    parameter int Width         = 6,
    parameter int NumCh         = 4,
    parameter int ChW           = 2,
    parameter int AvgLog2       = 2,
    parameter int SettleCycles  = 3,
    parameter int TimeoutCycles = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scan_i,
    input  logic             cont_i,
    input  logic [NumCh-1:0] ch_en_i,
    output logic             sar_start_o,
    input  logic             sar_eoc_i,
    input  logic [Width-1:0] sar_result_i,
    output logic [ChW-1:0]   ch_sel_o,
    output logic             busy_o,
    output logic             scan_done_o,
    output logic             timeout_o,
    input  logic [ChW-1:0]   rd_ch_i,
    output logic [Width-1:0] rd_data_o,
    output logic             rd_valid_o
);

    localparam int AccW = Width + AvgLog2;
    localparam int SmpW = AvgLog2 + 1;
    localparam int SetW = cnt_w(SettleCycles);
    localparam int TmoW = cnt_w(TimeoutCycles);
    localparam logic [SmpW-1:0] NumSamples = SmpW'(1 << AvgLog2);

    seq_state_e       state_q, state_d;
    logic [NumCh-1:0] mask_q, done_q, todo;
    logic [ChW-1:0]   ch_q, pick;
    logic             found;
    logic [SetW-1:0]  settle_q;
    logic [TmoW-1:0]  tmo_q;
    logic [SmpW-1:0]  smp_q;
    logic [AccW-1:0]  acc_q;
    logic             timeout_q;
    logic             scan_go, relatch, settle_end, tmo_hit, smp_full;
    logic             bank_we, bank_set;
    logic [Width-1:0] bank_data;

    assign scan_go    = scan_i && (ch_en_i != '0);
    assign relatch    = cont_i && (ch_en_i != '0);
    assign settle_end = (settle_q == SetW'(SettleCycles - 1));
    assign tmo_hit    = !sar_eoc_i && (tmo_q == TmoW'(TimeoutCycles - 1));
    assign smp_full   = (smp_q == NumSamples);
    assign todo       = mask_q & ~done_q;
    assign bank_data  = Width'(acc_q >> AvgLog2);

    // Lowest-index enabled channel not yet visited in this scan.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (todo[i]) begin
                pick  = ChW'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sar_start_o = 1'b0;
        scan_done_o = 1'b0;
        bank_we     = 1'b0;
        bank_set    = 1'b0;
        case (state_q)
            ST_IDLE:     if (scan_go) state_d = ST_SELECT;
            ST_SELECT:   state_d = found ? ST_SETTLE : ST_DONE;
            ST_SETTLE:   if (settle_end) state_d = ST_START;
            ST_START: begin
                sar_start_o = 1'b1;
                state_d     = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
                if (sar_eoc_i) begin
                    state_d = ST_STORE;
                end else if (tmo_hit) begin
                    bank_we = 1'b1;
                    state_d = ST_SELECT;
                end
            end
            ST_STORE: begin
                if (smp_full) begin
                    bank_we  = 1'b1;
                    bank_set = 1'b1;
                    state_d  = ST_SELECT;
                end else begin
                    state_d  = ST_START;
                end
            end
            ST_DONE: begin
                scan_done_o = 1'b1;
                state_d     = relatch ? ST_SELECT : ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q    <= '0;
            done_q    <= '0;
            ch_q      <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
            smp_q     <= '0;
            acc_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_go) begin
                        mask_q    <= ch_en_i;
                        done_q    <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    if (found) begin
                        ch_q         <= pick;
                        done_q[pick] <= 1'b1;
                        settle_q     <= '0;
                        smp_q        <= '0;
                        acc_q        <= '0;
                    end
                end
                ST_SETTLE:   settle_q <= settle_q + SetW'(1);
                ST_START:    tmo_q    <= '0;
                ST_WAIT_EOC: begin
                    if (sar_eoc_i) begin
                        acc_q <= acc_q + AccW'(sar_result_i);
                        smp_q <= smp_q + SmpW'(1);
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                        if (tmo_hit) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (relatch) begin
                        mask_q <= ch_en_i;
                        done_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ch_sel_o  = ch_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign timeout_o = timeout_q;

    sar_result_bank #(
        .Width (Width),
        .NumCh (NumCh),
        .ChW   (ChW)
    ) u_bank (
        .clk      (clk_i),
        .rst      (rst_i),
        .we       (bank_we),
        .wr_ch    (ch_q),
        .wr_data  (bank_data),
        .wr_set   (bank_set),
        .rd_ch    (rd_ch_i),
        .rd_data  (rd_data_o),
        .rd_valid (rd_valid_o)
    );

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb/tb_sar_scan_sequencer.sv - directed self-checking bench for sar_scan_sequencer
module tb_sar_scan_sequencer;
    import sar_seq_pkg::*;

    localparam int SettleCycles = 3;

    logic       clk = 1'b0;
    logic       rst_i, scan_i, cont_i;
    logic [3:0] ch_en_i;
    logic       sar_start_o, sar_eoc_i;
    logic [5:0] sar_result_i;
    logic [1:0] ch_sel_o;
    logic       busy_o, scan_done_o, timeout_o;
    logic [1:0] rd_ch_i;
    logic [5:0] rd_data_o;
    logic       rd_valid_o;

    always #5 clk = ~clk;

    sar_scan_sequencer #(
        .Width(6), .NumCh(4), .ChW(2), .AvgLog2(2),
        .SettleCycles(SettleCycles), .TimeoutCycles(64)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .scan_i(scan_i), .cont_i(cont_i),
        .ch_en_i(ch_en_i), .sar_start_o(sar_start_o), .sar_eoc_i(sar_eoc_i),
        .sar_result_i(sar_result_i), .ch_sel_o(ch_sel_o), .busy_o(busy_o),
        .scan_done_o(scan_done_o), .timeout_o(timeout_o), .rd_ch_i(rd_ch_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SAR model: eoc 7 cycles after each start, values taken per channel in order.
    logic [5:0] vals [4][4];
    logic [3:0] mute;
    int         smp [4] = '{0, 0, 0, 0};
    int         cd = 0, mch = 0;
    logic       model_eoc = 1'b0, spur_eoc;
    logic [5:0] model_val = '0, spur_val;
    int         starts = 0, dones = 0, settles = 0;
    int         chan_cnt [4] = '{0, 0, 0, 0};
    int         start_cyc [$];

    assign sar_eoc_i    = model_eoc | spur_eoc;
    assign sar_result_i = spur_eoc ? spur_val : model_val;

    always @(negedge clk) begin
        model_eoc = 1'b0;
        if (rst_i) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !mute[mch]) begin
                    model_eoc = 1'b1;
                    model_val = vals[mch][smp[mch] % 4];
                    smp[mch]++;
                end
            end
            if (sar_start_o) begin
                cd = 7;
                mch = int'(ch_sel_o);
                starts++;
                chan_cnt[ch_sel_o]++;
                start_cyc.push_back(cyc);
            end
            if (scan_done_o) dones++;
            if (dut.state_q == ST_SETTLE) settles++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_scan(input logic [3:0] en);
        ch_en_i = en;
        scan_i  = 1'b1;
        @(negedge clk);
        scan_i  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!scan_done_o && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done seen"}, 32'(scan_done_o), 1);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] ch, input int data, input logic valid);
        rd_ch_i = ch;
        #1;
        chk({tag, " data"}, 32'(rd_data_o), data);
        chk({tag, " valid"}, 32'(rd_valid_o), 32'(valid));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int b_st, b_dn, b_set, b_q, k;
    int b_cnt [4];

    task automatic snap();
        b_st = starts; b_dn = dones; b_set = settles; b_q = start_cyc.size();
        for (int i = 0; i < 4; i++) b_cnt[i] = chan_cnt[i];
    endtask

    initial begin
        rst_i = 1'b1; scan_i = 1'b0; cont_i = 1'b0; ch_en_i = '0; rd_ch_i = '0;
        spur_eoc = 1'b0; spur_val = '0; mute = '0;
        vals[0] = '{6'd10, 6'd11, 6'd12, 6'd13};
        vals[1] = '{6'd30, 6'd31, 6'd32, 6'd33};
        vals[2] = '{6'd40, 6'd40, 6'd40, 6'd41};
        vals[3] = '{6'd20, 6'd21, 6'd22, 6'd23};

        // Reset state
        tick(3);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst start", 32'(sar_start_o), 0);
        chk("rst done", 32'(scan_done_o), 0);
        chk("rst timeout", 32'(timeout_o), 0);
        chk("rst ch_sel", 32'(ch_sel_o), 0);
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) rd_chk("rst rd", 2'(c), 0, 1'b0);

        // Single scan of ch0 and ch2
        tick(1);
        snap();
        start_scan(4'b0101);
        chk("t1 busy", 32'(busy_o), 1);
        k = 0;
        while (!sar_start_o && k < 20) begin tick(1); k++; end
        // One cycle leaving SELECT plus the settle cycles before START.
        chk("t1 first start latency", k, SettleCycles + 1);
        wait_done("t1", 400);
        tick(1);
        chk("t1 idle after done", 32'(busy_o), 0);
        tick(2);
        chk("t1 starts", starts - b_st, 8);
        chk("t1 ch0 starts", chan_cnt[0] - b_cnt[0], 4);
        chk("t1 ch2 starts", chan_cnt[2] - b_cnt[2], 4);
        chk("t1 dones", dones - b_dn, 1);
        chk("t1 settle cycles", settles - b_set, 6);
        chk("t1 sample gap", start_cyc[b_q + 1] - start_cyc[b_q], 9);
        chk("t1 channel gap", start_cyc[b_q + 4] - start_cyc[b_q + 3], 13);
        chk("t1 timeout", 32'(timeout_o), 0);
        rd_chk("t1 ch0", 2'd0, 11, 1'b1);
        rd_chk("t1 ch2", 2'd2, 40, 1'b1);
        rd_chk("t1 ch1", 2'd1, 0, 1'b0);
        rd_chk("t1 ch3", 2'd3, 0, 1'b0);

        // Ignored requests
        tick(1);
        snap();
        ch_en_i = 4'b0000;
        scan_i = 1'b1;
        tick(1);
        scan_i = 1'b0;
        chk("t2 zero mask busy", 32'(busy_o), 0);
        tick(3);
        chk("t2 zero mask still idle", 32'(busy_o), 0);
        chk("t2 zero mask no done", dones - b_dn, 0);
        snap();
        start_scan(4'b0010);
        ch_en_i = 4'b1111;
        scan_i = 1'b1;
        tick(1);
        scan_i = 1'b0;
        spur_eoc = 1'b1;
        spur_val = 6'd63;
        tick(1);
        spur_eoc = 1'b0;
        scan_i = 1'b1;
        tick(1);
        scan_i = 1'b0;
        wait_done("t2", 400);
        tick(2);
        chk("t2 idle", 32'(busy_o), 0);
        chk("t2 starts", starts - b_st, 4);
        chk("t2 ch1 starts", chan_cnt[1] - b_cnt[1], 4);
        chk("t2 ch0 untouched", chan_cnt[0] - b_cnt[0], 0);
        chk("t2 ch3 untouched", chan_cnt[3] - b_cnt[3], 0);
        chk("t2 dones", dones - b_dn, 1);
        rd_chk("t2 ch1", 2'd1, 31, 1'b1);
        rd_chk("t2 ch0 kept", 2'd0, 11, 1'b1);

        // Timeout on ch1
        tick(1);
        mute = 4'b0010;
        snap();
        start_scan(4'b1010);
        wait_done("t3", 800);
        tick(2);
        chk("t3 timeout", 32'(timeout_o), 1);
        chk("t3 starts", starts - b_st, 5);
        chk("t3 ch1 starts", chan_cnt[1] - b_cnt[1], 1);
        chk("t3 ch3 starts", chan_cnt[3] - b_cnt[3], 4);
        chk("t3 timeout gap", start_cyc[b_q + 1] - start_cyc[b_q], 69);
        chk("t3 dones", dones - b_dn, 1);
        rd_chk("t3 ch1", 2'd1, 31, 1'b0);
        rd_chk("t3 ch3", 2'd3, 21, 1'b1);

        // Continuous mode with a mid-scan mask change
        tick(1);
        mute = 4'b0000;
        vals[0] = '{6'd5, 6'd6, 6'd7, 6'd8};
        vals[3] = '{6'd50, 6'd52, 6'd54, 6'd56};
        cont_i = 1'b1;
        snap();
        start_scan(4'b0001);
        chk("t4 timeout cleared", 32'(timeout_o), 0);
        ch_en_i = 4'b1000;
        wait_done("t4 scan1", 400);
        chk("t4 scan1 ch0", chan_cnt[0] - b_cnt[0], 4);
        chk("t4 scan1 ch3", chan_cnt[3] - b_cnt[3], 0);
        tick(1);
        cont_i = 1'b0;
        chk("t4 rescan busy", 32'(busy_o), 1);
        wait_done("t4 scan2", 400);
        tick(1);
        chk("t4 idle", 32'(busy_o), 0);
        tick(10);
        chk("t4 dones", dones - b_dn, 2);
        chk("t4 ch3 starts", chan_cnt[3] - b_cnt[3], 4);
        chk("t4 ch0 starts", chan_cnt[0] - b_cnt[0], 4);
        rd_chk("t4 ch0", 2'd0, 6, 1'b1);
        rd_chk("t4 ch3", 2'd3, 53, 1'b1);

        // Reset in the middle of a scan
        tick(1);
        start_scan(4'b1111);
        tick(20);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t5 rst busy", 32'(busy_o), 0);
            chk("t5 rst start", 32'(sar_start_o), 0);
        end
        chk("t5 rst done", 32'(scan_done_o), 0);
        chk("t5 rst timeout", 32'(timeout_o), 0);
        chk("t5 rst ch_sel", 32'(ch_sel_o), 0);
        for (int c = 0; c < 4; c++) rd_chk("t5 rst rd", 2'(c), 0, 1'b0);
        rst_i = 1'b0;
        tick(1);
        chk("t5 post start", 32'(sar_start_o), 0);
        tick(5);
        chk("t5 post busy", 32'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
